// File: rtl/mac_dot.sv
// mac_dot: pipelined LANES-wide dot-product accumulator with valid/ready handshakes.
// Optional build macro MAC_SAT_EN selects saturating arithmetic with a per-frame overflow flag.
module mac_dot #(
    parameter int IN_W   = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 20,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IN_W-1:0] in_a,
    input  logic [LANES*IN_W-1:0] in_b,
    input  logic                  in_last,
    output logic                  acc_valid,
    input  logic                  acc_ready,
    output logic [ACC_W-1:0]      acc_data,
    output logic                  acc_ovf
);

    localparam int  PW   = 2 * IN_W;
    localparam bit  IS_S = (SIGNED != 0);
`ifdef MAC_SAT_EN
    localparam int  SW   = ACC_W + 1;
`else
    localparam int  SW   = ACC_W;
`endif

    if (LANES < 1 || ACC_W < 2 * IN_W + $clog2(LANES)) begin : g_param_err
        $error("mac_dot: LANES must be >= 1 and ACC_W >= 2*IN_W+$clog2(LANES)");
    end

    function automatic logic [PW-1:0] ext_op(input logic [IN_W-1:0] v);
        logic [PW-1:0] r;
        r = {PW{IS_S & v[IN_W-1]}};
        r[IN_W-1:0] = v;
        return r;
    endfunction

    function automatic logic [SW-1:0] ext_prod(input logic [PW-1:0] p);
        logic [SW-1:0] r;
        r = {SW{IS_S & p[PW-1]}};
        r[PW-1:0] = p;
        return r;
    endfunction

    logic [PW-1:0]    prod_s [LANES];
    logic [PW-1:0]    prod_r [LANES];
    logic             p_vld_r;
    logic             p_last_r;
    logic [SW-1:0]    sum_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_next_s;
    logic             first_r;
    logic             acc_valid_r;
    logic [ACC_W-1:0] acc_data_r;
    logic             adv_s;

    assign adv_s     = !(acc_valid_r && !acc_ready) && !clr;
    assign in_ready  = adv_s;
    assign acc_valid = acc_valid_r;
    assign acc_data  = acc_data_r;

    // Lane products: operands widened first so the PW-bit product is exact in both modes.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_s[i] = ext_op(in_a[i*IN_W +: IN_W]) * ext_op(in_b[i*IN_W +: IN_W]);
        end
    end

    // Sum of registered products at full width.
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + ext_prod(prod_r[i]);
        end
    end

`ifdef MAC_SAT_EN
    logic [SW-1:0] base_s;
    logic [SW-1:0] wide_s;
    logic          ovf_s;
    logic          ovf_sticky_r;
    logic          acc_ovf_r;

    // Guard-bit add, overflow detection and clamp.
    always_comb begin
        if (first_r) begin
            base_s = {SW{1'b0}};
        end else begin
            base_s = {IS_S & acc_r[ACC_W-1], acc_r};
        end
        wide_s = base_s + sum_s;
        if (IS_S) begin
            ovf_s = wide_s[ACC_W] ^ wide_s[ACC_W-1];
        end else begin
            ovf_s = wide_s[ACC_W];
        end
        if (!ovf_s) begin
            acc_next_s = wide_s[ACC_W-1:0];
        end else if (IS_S) begin
            acc_next_s = wide_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_next_s = {ACC_W{1'b1}};
        end
    end

    // Sticky frame overflow; published alongside the frame result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_sticky_r <= 1'b0;
            acc_ovf_r    <= 1'b0;
        end else if (clr) begin
            ovf_sticky_r <= 1'b0;
            acc_ovf_r    <= 1'b0;
        end else if (adv_s && p_vld_r) begin
            if (p_last_r) begin
                acc_ovf_r    <= ovf_sticky_r | ovf_s;
                ovf_sticky_r <= 1'b0;
            end else begin
                ovf_sticky_r <= ovf_sticky_r | ovf_s;
            end
        end
    end

    assign acc_ovf = acc_ovf_r;
`else
    // Modulo accumulate: no guard bit, result wraps at 2^ACC_W.
    always_comb begin
        if (first_r) begin
            acc_next_s = sum_s;
        end else begin
            acc_next_s = acc_r + sum_s;
        end
    end

    assign acc_ovf = 1'b0;
`endif

    // Product stage, accumulator and result register; everything freezes when adv_s is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_r      <= '{default: {PW{1'b0}}};
            p_vld_r     <= 1'b0;
            p_last_r    <= 1'b0;
            acc_r       <= {ACC_W{1'b0}};
            first_r     <= 1'b1;
            acc_valid_r <= 1'b0;
            acc_data_r  <= {ACC_W{1'b0}};
        end else if (clr) begin
            p_vld_r     <= 1'b0;
            acc_r       <= {ACC_W{1'b0}};
            first_r     <= 1'b1;
            acc_valid_r <= 1'b0;
        end else begin
            if (acc_valid_r && acc_ready) begin
                acc_valid_r <= 1'b0;
            end
            if (adv_s) begin
                prod_r   <= prod_s;
                p_vld_r  <= in_valid;
                p_last_r <= in_last;
                if (p_vld_r) begin
                    if (p_last_r) begin
                        acc_data_r  <= acc_next_s;
                        acc_valid_r <= 1'b1;
                        first_r     <= 1'b1;
                    end else begin
                        acc_r   <= acc_next_s;
                        first_r <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_dot.sv
// Self-checking bench for mac_dot: directed scenarios plus randomized traffic against a frame-level model.
// Expectations follow MAC_SAT_EN when the bundle is built with it.
module tb_mac_dot;

    localparam int ACC_W = 20;

    logic        clk = 1'b0;
    logic        reset, clr, in_valid, in_ready, in_last, acc_valid, acc_ready, acc_ovf;
    logic [31:0] in_a, in_b;
    logic [19:0] acc_data;

    logic        s_in_valid, s_in_ready, s_in_last, s_acc_valid, s_acc_ovf;
    logic [31:0] s_in_a, s_in_b;
    logic [19:0] s_acc_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [20:0] exp_q[$];
    longint      m_acc   = 0;
    bit          m_first = 1'b1;
    bit          m_ovf   = 1'b0;

    always #5 clk = ~clk;

    mac_dot #(.IN_W(8), .LANES(4), .ACC_W(20), .SIGNED(0)) dut (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .acc_data(acc_data), .acc_ovf(acc_ovf)
    );

    mac_dot #(.IN_W(8), .LANES(4), .ACC_W(20), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .clr(1'b0), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_last(s_in_last), .acc_valid(s_acc_valid),
        .acc_ready(1'b1), .acc_data(s_acc_data), .acc_ovf(s_acc_ovf)
    );

    function automatic logic [31:0] pack4(input logic [7:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic longint dot4(input logic [31:0] a, b, input bit sgn);
        longint s = 0;
        logic [7:0] x, y;
        for (int i = 0; i < 4; i++) begin
            x = a[i*8 +: 8];
            y = b[i*8 +: 8];
            if (sgn) s += longint'($signed(x)) * longint'($signed(y));
            else     s += longint'(x) * longint'(y);
        end
        return s;
    endfunction

    // One beat of frame arithmetic: add, then clamp (saturating build) or wrap.
    function automatic void model_step(input longint base, input longint dot, input bit sgn,
                                       output longint res, output bit ovf);
        longint t, lo, hi;
        t   = base + dot;
        ovf = 1'b0;
`ifdef MAC_SAT_EN
        if (sgn) begin
            lo = -(longint'(1) <<< (ACC_W - 1));
            hi = (longint'(1) <<< (ACC_W - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) <<< ACC_W) - 1;
        end
        if (t > hi) begin
            t = hi; ovf = 1'b1;
        end else if (t < lo) begin
            t = lo; ovf = 1'b1;
        end
`else
        lo = 0;
        hi = longint'(1) <<< ACC_W;
        t  = t & (hi - 1);
        if (sgn && t >= (hi >>> 1)) t = t - hi;
`endif
        res = t;
    endfunction

    // Scoreboard: model every accepted beat, check every consumed result.
    longint mon_t;
    bit     mon_o;
    logic [20:0] mon_e;
    always @(negedge clk) begin
        if (!reset || clr) begin
            exp_q.delete();
            m_acc = 0; m_first = 1'b1; m_ovf = 1'b0;
        end else begin
            if (acc_valid && acc_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL result_unexpected: got %0d, none expected", acc_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({acc_ovf, acc_data} !== mon_e) begin
                        n_fail++;
                        $display("FAIL result_model: got data=%0d ovf=%0b, expected data=%0d ovf=%0b",
                                 acc_data, acc_ovf, mon_e[19:0], mon_e[20]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                model_step(m_first ? 0 : m_acc, dot4(in_a, in_b, 1'b0), 1'b0, mon_t, mon_o);
                if (in_last) begin
                    exp_q.push_back({m_ovf | mon_o, mon_t[19:0]});
                    m_acc = 0; m_first = 1'b1; m_ovf = 1'b0;
                end else begin
                    m_acc = mon_t; m_first = 1'b0; m_ovf = m_ovf | mon_o;
                end
            end
        end
    end

    // Present a beat and hold it until accepted; returns at edge+1.
    task automatic drive_beat(input logic [31:0] a, b, input logic last);
        bit ok = 1'b0;
        int cyc = 0;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        while (!ok && cyc < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL beat_accept: got no acceptance in %0d cycles, expected acceptance", cyc);
        end
    endtask

    task automatic wait_valid(output bit ok);
        int cyc = 0;
        while (!acc_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        ok = acc_valid;
    endtask

    task automatic drain();
        int cyc = 0;
        acc_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_checks++;
        if ({acc_valid, acc_ovf, acc_data} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b ovf=%0b data=%0d, expected all 0",
                     acc_valid, acc_ovf, acc_data);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b, expected 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat();
        drive_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1);
        n_checks++;
        if (acc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got acc_valid=%0b one edge after accept, expected 0", acc_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({acc_valid, acc_ovf, acc_data} !== {1'b1, 1'b0, 20'd70}) begin
            n_fail++;
            $display("FAIL single_beat: got valid=%0b ovf=%0b data=%0d, expected valid=1 ovf=0 data=70",
                     acc_valid, acc_ovf, acc_data);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ones, twos;
        ones = pack4(8'd1, 8'd1, 8'd1, 8'd1);
        twos = pack4(8'd2, 8'd2, 8'd2, 8'd2);
        drive_beat(ones, ones, 1'b0);
        drive_beat(ones, ones, 1'b0);
        drive_beat(ones, ones, 1'b1);
        drive_beat(twos, twos, 1'b1);
        n_checks++;
        if ({acc_valid, acc_data} !== {1'b1, 20'd12}) begin
            n_fail++;
            $display("FAIL frame3: got valid=%0b data=%0d, expected valid=1 data=12", acc_valid, acc_data);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({acc_valid, acc_data} !== {1'b1, 20'd16}) begin
            n_fail++;
            $display("FAIL frame1_after: got valid=%0b data=%0d, expected valid=1 data=16", acc_valid, acc_data);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] ones;
        ones = pack4(8'd1, 8'd1, 8'd1, 8'd1);
        acc_ready = 1'b0;
        drive_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1);
        in_a = ones; in_b = ones; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, acc_valid, acc_data} !== {1'b0, 1'b1, 20'd70}) begin
                n_fail++;
                $display("FAIL stall_hold: got in_ready=%0b valid=%0b data=%0d, expected 0/1/70",
                         in_ready, acc_valid, acc_data);
            end
            @(posedge clk); #1;
        end
        acc_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({acc_valid, acc_data} !== {1'b1, 20'd4}) begin
            n_fail++;
            $display("FAIL after_stall: got valid=%0b data=%0d, expected valid=1 data=4", acc_valid, acc_data);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [31:0] ff;
        bit ok;
        ff = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) drive_beat(ff, ff, (i == 4) ? 1'b1 : 1'b0);
        wait_valid(ok);
        n_checks++;
`ifdef MAC_SAT_EN
        if (!ok || {acc_ovf, acc_data} !== {1'b1, 20'd1048575}) begin
            n_fail++;
            $display("FAIL saturate: got valid=%0b ovf=%0b data=%0d, expected ovf=1 data=1048575",
                     ok, acc_ovf, acc_data);
        end
`else
        if (!ok || {acc_ovf, acc_data} !== {1'b0, 20'd251924}) begin
            n_fail++;
            $display("FAIL wrap: got valid=%0b ovf=%0b data=%0d, expected ovf=0 data=251924",
                     ok, acc_ovf, acc_data);
        end
`endif
        drain();
    endtask

    task automatic test_signed();
        longint t1, t2;
        bit o1, o2, ok;
        int cyc = 0;
        s_in_a = pack4(8'h80, 8'h80, 8'h80, 8'h80);
        s_in_b = pack4(8'h7F, 8'h7F, 8'h7F, 8'h7F);
        model_step(0, dot4(s_in_a, s_in_b, 1'b1), 1'b1, t1, o1);
        model_step(t1, dot4(s_in_a, s_in_b, 1'b1), 1'b1, t2, o2);
        s_in_valid = 1'b1; s_in_last = 1'b0;
        @(posedge clk); #1;
        s_in_last = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_in_last = 1'b0;
        while (!s_acc_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        ok = s_acc_valid;
        n_checks++;
        if (!ok || {s_acc_ovf, s_acc_data} !== {o1 | o2, t2[19:0]}) begin
            n_fail++;
            $display("FAIL signed: got valid=%0b ovf=%0b data=%0d, expected ovf=%0b data=%0d",
                     ok, s_acc_ovf, $signed(s_acc_data), o1 | o2, t2);
        end
    endtask

    task automatic test_clr();
        logic [31:0] ones;
        bit ok;
        ones = pack4(8'd1, 8'd1, 8'd1, 8'd1);
        drive_beat(ones, ones, 1'b0);
        drive_beat(ones, ones, 1'b0);
        clr = 1'b1;
        in_a = ones; in_b = ones; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_in_ready: got %0b, expected 0", in_ready);
        end
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        drive_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1);
        wait_valid(ok);
        n_checks++;
        if (!ok || acc_data !== 20'd70) begin
            n_fail++;
            $display("FAIL clr_restart: got valid=%0b data=%0d, expected valid=1 data=70", ok, acc_data);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [31:0] ones;
        bit ok;
        ones = pack4(8'd1, 8'd1, 8'd1, 8'd1);
        drive_beat(ones, ones, 1'b0);
        drive_beat(ones, ones, 1'b0);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({acc_valid, acc_ovf, acc_data} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got valid=%0b ovf=%0b data=%0d, expected all 0",
                     acc_valid, acc_ovf, acc_data);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        drive_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd5, 8'd6, 8'd7, 8'd8), 1'b1);
        wait_valid(ok);
        n_checks++;
        if (!ok || acc_data !== 20'd70) begin
            n_fail++;
            $display("FAIL reset_restart: got valid=%0b data=%0d, expected valid=1 data=70", ok, acc_data);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_a      = $urandom;
            in_b      = $urandom;
            in_last   = ($urandom_range(3) == 0);
            acc_ready = ($urandom_range(2) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drive_beat($urandom, $urandom, 1'b1);
        drain();
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; acc_ready = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_a = 32'd0; in_b = 32'd0;
        s_in_valid = 1'b0; s_in_last = 1'b0; s_in_a = 32'd0; s_in_b = 32'd0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_signed();
        test_clr();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
